// File: rtl/mem_pkg.sv
// Shared types and widths for the main-RAM arbiter between icache and dcache.
package mem_pkg;

    localparam int ADDR_W = 26;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef enum logic {
        REQ_IC,
        REQ_DC
    } req_id_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side handshakes and RAM-side bus seen by mem_arbiter.
interface mem_arbiter_if
    import mem_pkg::*;
();

    // icache line-read port
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    line_t             ic_rdata;

    // dcache read / writeback port
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    line_t             dc_wdata;
    logic              dc_ready;
    line_t             dc_rdata;

    // single-port RAM side
    logic [ADDR_W-1:0] mem_read_addr;
    logic [ADDR_W-1:0] mem_write_addr;
    line_t             mem_wdata;
    logic              mem_we;
    line_t             mem_rdata;

    // arbiter side
    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        output ic_ready, ic_rdata, dc_ready, dc_rdata,
        output mem_read_addr, mem_write_addr, mem_wdata, mem_we
    );

    // caches + RAM side
    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata,
        input  mem_read_addr, mem_write_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that did not win last time is chosen.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic [1:0] req,        // [0] = icache, [1] = dcache
    input  req_id_t    last_grant,
    output logic       gnt_valid,
    output req_id_t    gnt_id
);

    // Pick the winner for this cycle
    always_comb begin
        gnt_valid = req[0] | req[1];
        gnt_id    = REQ_IC;
        if (req[0] && req[1]) begin
            gnt_id = (last_grant == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (req[1]) begin
            gnt_id = REQ_DC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main RAM between icache line reads and dcache
// reads/writebacks. One access at a time: grant, MEM_LATENCY busy cycles,
// then a one-cycle ready pulse to the winner.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] count;
    req_id_t          last_grant;
    req_id_t          lat_id;
    logic             lat_we;
    logic             gnt_valid;
    req_id_t          gnt_id;
    logic             grant_now;
    logic             last_busy;

    // A grant is only taken in IDLE; the final busy cycle is when count hits zero.
    assign grant_now = (state == IDLE) && gnt_valid;
    assign last_busy = (state == BUSY) && (count == '0);

    rr_arbiter2 u_arb (
        .req        ({bus.dc_req, bus.ic_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Next-state logic for IDLE -> BUSY -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = BUSY;
            BUSY:    if (count == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Latency counter and latched grant information
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            last_grant <= REQ_IC;   // so the dcache wins the first tie
            lat_id     <= REQ_IC;
            lat_we     <= 1'b0;
        end else if (grant_now) begin
            count      <= CNT_LOAD;
            last_grant <= gnt_id;
            lat_id     <= gnt_id;
            lat_we     <= (gnt_id == REQ_DC) && bus.dc_we;
        end else if ((state == BUSY) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // RAM-side address/data latches and returned-line registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_read_addr  <= '0;
            bus.mem_write_addr <= '0;
            bus.mem_wdata      <= '0;
            bus.ic_rdata       <= '0;
            bus.dc_rdata       <= '0;
        end else begin
            if (grant_now) begin
                // Requester inputs may change after this edge; only the latched copies are used.
                bus.mem_read_addr  <= (gnt_id == REQ_DC) ? bus.dc_addr : bus.ic_addr;
                bus.mem_write_addr <= (gnt_id == REQ_DC) ? bus.dc_addr : bus.ic_addr;
                bus.mem_wdata      <= (gnt_id == REQ_DC) ? bus.dc_wdata : '0;
            end
            if (last_busy && !lat_we) begin
                if (lat_id == REQ_IC) bus.ic_rdata <= bus.mem_rdata;
                else                  bus.dc_rdata <= bus.mem_rdata;
            end
        end
    end

    // Write strobe and ready pulses are killed immediately by reset so an
    // aborted access never reaches the RAM or the caches.
    assign bus.mem_we   = last_busy && lat_we && !reset;
    assign bus.ic_ready = (state == RESP) && (lat_id == REQ_IC) && !reset;
    assign bus.dc_ready = (state == RESP) && (lat_id == REQ_DC) && !reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: word-addressed RAM fixture, line-level reference
// model, directed scenarios plus randomized request rounds.
module tb_mem_arbiter;

    localparam int L  = 4;
    localparam int NL = 64;   // lines held by the RAM fixture

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.MEM_LATENCY(L)) dut4 (.clk(clk), .reset(reset), .bus(bus));
    mem_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // RAM fixture: 32-bit words, a line is four consecutive words
    logic [31:0]  words [0:NL*4-1];
    logic [127:0] mline [0:NL-1];   // reference model memory, one entry per line

    function automatic logic [127:0] rd_line(input int a);
        return {words[a*4+3], words[a*4+2], words[a*4+1], words[a*4]};
    endfunction

    always_comb bus.mem_rdata  = rd_line(int'(bus.mem_read_addr) % NL);
    always_comb bus1.mem_rdata = rd_line(int'(bus1.mem_read_addr) % NL);

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                words[(int'(bus.mem_write_addr) % NL)*4+i] <= bus.mem_wdata[32*i +: 32];
        end
    end

    // cycle counter and output monitor
    int           cyc = 0;
    int           ic_pulses = 0, dc_pulses = 0, we_cnt = 0, both_ready = 0;
    int           we_cyc;
    logic [25:0]  we_addr;
    logic [127:0] we_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ic_ready) ic_pulses++;
        if (bus.dc_ready) dc_pulses++;
        if (bus.ic_ready && bus.dc_ready) both_ready++;
        if (bus.mem_we) begin
            we_cnt++;
            we_cyc  = cyc;
            we_addr = bus.mem_write_addr;
            we_data = bus.mem_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference model state
    bit           last_dc;   // 1 = dcache was served last
    logic [127:0] exp_ic_rd, exp_dc_rd;

    // One round: the chosen requesters raise req together in an IDLE cycle,
    // each drops req right after its own ready.
    task automatic run_round(input bit do_ic, input bit do_dc, input bit dc_wr,
                             input int ia, input int da, input logic [127:0] wd);
        int t0, ic_c, dc_c, g_ic, g_dc, ic_p0, dc_p0, we0;
        bit got_ic, got_dc, first_dc, done;
        logic [127:0] ic_d, dc_d;
        first_dc = do_dc && (!do_ic || !last_dc);
        g_ic = first_dc ? L + 2 : 0;
        g_dc = first_dc ? 0 : L + 2;
        for (int s = 0; s < 2; s++) begin
            bit is_dc;
            is_dc = (s == 0) ? first_dc : !first_dc;
            if (is_dc && do_dc) begin
                if (dc_wr) mline[da] = wd;
                else       exp_dc_rd = mline[da];
                last_dc = 1'b1;
            end else if (!is_dc && do_ic) begin
                exp_ic_rd = mline[ia];
                last_dc   = 1'b0;
            end
        end
        ic_p0 = ic_pulses; dc_p0 = dc_pulses; we0 = we_cnt;
        ic_c = -1; dc_c = -1; ic_d = '0; dc_d = '0;
        got_ic = 1'b0; got_dc = 1'b0; done = 1'b0;
        bus.ic_req   = do_ic;
        bus.ic_addr  = 26'(ia);
        bus.dc_req   = do_dc;
        bus.dc_we    = dc_wr;
        bus.dc_addr  = 26'(da);
        bus.dc_wdata = wd;
        t0 = cyc;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (bus.ic_ready && !got_ic) begin got_ic = 1'b1; ic_c = cyc; ic_d = bus.ic_rdata; end
            if (bus.dc_ready && !got_dc) begin got_dc = 1'b1; dc_c = cyc; dc_d = bus.dc_rdata; end
            @(posedge clk); #1;
            if (got_ic) bus.ic_req = 1'b0;
            if (got_dc) bus.dc_req = 1'b0;
            done = (got_ic || !do_ic) && (got_dc || !do_dc);
        end
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        check("round_done", done, 1'b1);
        if (do_ic) begin
            check("ic_latency", ic_c - t0, g_ic + L + 1);
            check("ic_rdata", ic_d, exp_ic_rd);
        end
        if (do_dc) begin
            check("dc_latency", dc_c - t0, g_dc + L + 1);
            check("dc_rdata", dc_d, exp_dc_rd);
        end
        check("ic_pulses", ic_pulses - ic_p0, do_ic);
        check("dc_pulses", dc_pulses - dc_p0, do_dc);
        check("we_pulses", we_cnt - we0, do_dc && dc_wr);
        if (do_dc && dc_wr) begin
            check("we_addr", we_addr, da);
            check("we_data", we_data, wd);
            check("we_cycle", we_cyc - t0, g_dc + L);
        end
    endtask

    // Hold a read request high through ready and collect two ready pulses.
    task automatic hold_read(input bit on_l1, input int a, output int c0, output int c1,
                             output int k, output logic [127:0] d);
        int t0;
        int rc [2];
        k = 0; rc[0] = -1; rc[1] = -1; d = '0;
        if (on_l1) begin bus1.dc_req = 1'b1; bus1.dc_we = 1'b0; bus1.dc_addr = 26'(a); end
        else       begin bus.dc_req  = 1'b1; bus.dc_we  = 1'b0; bus.dc_addr  = 26'(a); end
        t0 = cyc;
        for (int n = 0; n < 40 && k < 2; n++) begin
            @(negedge clk);
            if (on_l1 ? bus1.dc_ready : bus.dc_ready) begin
                rc[k] = cyc;
                d = on_l1 ? bus1.dc_rdata : bus.dc_rdata;
                k++;
            end
            @(posedge clk); #1;
        end
        bus.dc_req = 1'b0;
        bus1.dc_req = 1'b0;
        c0 = rc[0] - t0;
        c1 = rc[1] - t0;
    endtask

    initial begin
        int c0, c1, k, ip0, dp0, we0, t0;
        bit got;
        logic [127:0] d;

        for (int i = 0; i < NL*4; i++) words[i] = $urandom;
        for (int i = 0; i < NL; i++) mline[i] = {words[i*4+3], words[i*4+2], words[i*4+1], words[i*4]};
        last_dc = 1'b0; exp_ic_rd = '0; exp_dc_rd = '0;

        bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus1.ic_req = 0; bus1.ic_addr = '0; bus1.dc_req = 0; bus1.dc_we = 0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ic_ready", bus.ic_ready, 0);
        check("rst_dc_ready", bus.dc_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_ic_rdata", bus.ic_rdata, 0);
        check("rst_dc_rdata", bus.dc_rdata, 0);
        check("rst_rd_addr", bus.mem_read_addr, 0);
        check("rst_wr_addr", bus.mem_write_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);

        // tie after reset: dcache first, twice in a row
        run_round(1, 1, 0, 3, 4, '0);
        run_round(1, 1, 0, 6, 8, '0);
        // single icache read of line 0
        run_round(1, 0, 0, 0, 0, '0);
        // writeback then read-back of line 5
        run_round(0, 1, 1, 0, 5, {16{8'hA5}});
        run_round(1, 0, 0, 5, 0, '0);
        check("a5_line", mline[5], {16{8'hA5}});

        // dcache holds req through ready: back-to-back accesses
        hold_read(1'b0, 20, c0, c1, k, d);
        exp_dc_rd = mline[20]; last_dc = 1'b1;
        check("hold_count", k, 2);
        check("hold_lat0", c0, L + 1);
        check("hold_lat1", c1, 2*L + 3);
        check("hold_rdata", d, exp_dc_rd);

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            bit di, dd, dw;
            di = 1'($urandom);
            dd = 1'($urandom);
            if (!di && !dd) dd = 1'b1;
            dw = 1'($urandom);
            run_round(di, dd, dw, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        check("never_both_ready", both_ready, 0);

        // reset in the second busy cycle of a writeback
        ip0 = ic_pulses; dp0 = dc_pulses; we0 = we_cnt;
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 26'd12;
        bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", dut4.state, mem_pkg::IDLE);
        check("abort_ic_rdata", bus.ic_rdata, 0);
        check("abort_dc_rdata", bus.dc_rdata, 0);
        check("abort_rd_addr", bus.mem_read_addr, 0);
        check("abort_wdata", bus.mem_wdata, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_we", we_cnt - we0, 0);
        check("abort_ic_ready", ic_pulses - ip0, 0);
        check("abort_dc_ready", dc_pulses - dp0, 0);
        last_dc = 1'b0; exp_ic_rd = '0; exp_dc_rd = '0;
        run_round(1, 1, 0, 12, 12, '0);   // line 12 untouched; dcache first again

        // MEM_LATENCY = 1 instance
        bus1.ic_req = 1'b1; bus1.ic_addr = 26'd7;
        t0 = cyc; got = 1'b0; c0 = -1; d = '0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (bus1.ic_ready) begin got = 1'b1; c0 = cyc; d = bus1.ic_rdata; end
            @(posedge clk); #1;
        end
        bus1.ic_req = 1'b0;
        check("l1_found", got, 1'b1);
        check("l1_latency", c0 - t0, 2);
        check("l1_rdata", d, mline[7]);
        hold_read(1'b1, 9, c0, c1, k, d);
        check("l1_hold_count", k, 2);
        check("l1_hold_lat0", c0, 2);
        check("l1_hold_lat1", c1, 5);
        check("l1_hold_rdata", d, mline[9]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
